// File: rtl/axis_snoop_tx.sv
// Packs 32-bit samples into 64-bit AXI-Stream beats, frames them, and buffers them in a small FIFO.
// Beats that find the FIFO full are dropped and counted; the producer is never stalled.
module axis_snoop_tx #(
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int FIFO_DEPTH             = 4,
    parameter int FRAME_BEATS            = 256
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic                              sample_valid,
    input  logic [31:0]                       sample_data,
    input  logic                              flush,
    input  logic                              m00_axis_tready,
    output logic                              m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic [7:0]                        m00_axis_tkeep,
    output logic                              m00_axis_tlast,
    output logic [15:0]                       drop_count,
    output logic                              overflow
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FRM_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int ENT_W = C_M00_AXIS_TDATA_WIDTH + 9;

    typedef enum logic {S_EMPTY, S_HALF} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                state_q, state_d;
    logic [31:0]           hold_q, hold_d;
    logic [FRM_W-1:0]      frm_q, frm_d;
    logic [PTR_W-1:0]      wr_q, rd_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [15:0]           drop_q;
    logic                  ovf_q;
    logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];

    logic                              push, flush_beat, push_last, accept, pop;
    logic [31:0]                       beat_lo, beat_hi;
    logic [7:0]                        push_keep;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] push_data;
    logic [ENT_W-1:0]                  head;

    // Pack FSM; flush is applied after the current cycle's sample has been taken.
    always_comb begin
        push       = 1'b0;
        flush_beat = 1'b0;
        beat_lo    = hold_q;
        beat_hi    = 32'h0;
        push_keep  = 8'hFF;
        state_d    = state_q;
        hold_d     = hold_q;
        case (state_q)
            S_EMPTY: begin
                if (sample_valid) begin
                    if (flush) begin
                        push       = 1'b1;
                        flush_beat = 1'b1;
                        beat_lo    = sample_data;
                        push_keep  = 8'h0F;
                    end else begin
                        hold_d  = sample_data;
                        state_d = S_HALF;
                    end
                end
            end
            S_HALF: begin
                if (sample_valid) begin
                    push       = 1'b1;
                    flush_beat = flush;
                    beat_hi    = sample_data;
                    state_d    = S_EMPTY;
                end else if (flush) begin
                    push       = 1'b1;
                    flush_beat = 1'b1;
                    push_keep  = 8'h0F;
                    state_d    = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign push_data = {beat_hi, beat_lo};
    assign push_last = flush_beat | (frm_q == FRM_W'(FRAME_BEATS - 1));
    assign pop       = m00_axis_tvalid & m00_axis_tready;
    // A full FIFO still takes a beat when the head leaves in the same cycle.
    assign accept    = push & ((count_q < CNT_W'(FIFO_DEPTH)) | pop);

    always_comb begin
        frm_d = frm_q;
        if (accept) frm_d = push_last ? '0 : frm_q + FRM_W'(1);
        count_d = count_q;
        if (accept && !pop)      count_d = count_q + CNT_W'(1);
        else if (!accept && pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q <= S_EMPTY;
            hold_q  <= 32'h0;
            frm_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            drop_q  <= 16'h0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            frm_q   <= frm_d;
            count_q <= count_d;
            if (accept) wr_q <= wr_q + PTR_W'(1);
            if (pop)    rd_q <= rd_q + PTR_W'(1);
            if (push && !accept) begin
                drop_q <= sat_inc(drop_q);
                ovf_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (accept) mem_q[wr_q] <= {push_last, push_keep, push_data};
    end

    // Outputs are gated by occupancy so an empty (or reset) FIFO presents zeros.
    assign head            = mem_q[rd_q];
    assign m00_axis_tvalid = (count_q != '0);
    assign m00_axis_tdata  = m00_axis_tvalid ? head[C_M00_AXIS_TDATA_WIDTH-1:0] : '0;
    assign m00_axis_tkeep  = m00_axis_tvalid ? head[C_M00_AXIS_TDATA_WIDTH+7:C_M00_AXIS_TDATA_WIDTH] : 8'h0;
    assign m00_axis_tlast  = m00_axis_tvalid & head[ENT_W-1];
    assign drop_count      = drop_q;
    assign overflow        = ovf_q;
endmodule

// File: tb/tb_axis_snoop_tx.sv
// Scoreboard bench for axis_snoop_tx: stimulus queues expected beats, a monitor checks each handshake.
module tb_axis_snoop_tx;
    localparam int FB = 4;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_data = 32'h0;
    logic        flush = 1'b0;
    logic        tready = 1'b0;
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic [15:0] drop_count;
    logic        overflow;

    int n_chk = 0;
    int n_fail = 0;
    logic [72:0] exp_q [$];

    axis_snoop_tx #(
        .C_M00_AXIS_TDATA_WIDTH(64),
        .FIFO_DEPTH(FD),
        .FRAME_BEATS(FB)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .flush(flush),
        .m00_axis_tready(tready),
        .m00_axis_tvalid(tvalid),
        .m00_axis_tdata(tdata),
        .m00_axis_tkeep(tkeep),
        .m00_axis_tlast(tlast),
        .drop_count(drop_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [72:0] beat(input logic [31:0] hi, input logic [31:0] lo,
                                         input logic [7:0] keep, input logic last);
        return {last, keep, hi, lo};
    endfunction

    always @(negedge clk) begin
        if (rst_n && tvalid && tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {tlast, tkeep, tdata}, 73'h0);
            end else begin
                chk("beat", {tlast, tkeep, tdata}, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic f);
        sample_valid = v;
        sample_data  = d;
        flush        = f;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample_data  = 32'h0;
        flush        = 1'b0;
    endtask

    task automatic pair(input logic [31:0] lo, input logic [31:0] hi, input logic last);
        drive(1'b1, lo, 1'b0);
        exp_q.push_back(beat(hi, lo, 8'hFF, last));
        drive(1'b1, hi, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(name, 73'(exp_q.size()), 73'h0);
        chk({name, "_idle"}, 73'(tvalid), 73'h0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        chk("rst_outputs", {tvalid, tlast, tkeep, drop_count, overflow}, 73'h0);
        chk("rst_tdata", 73'(tdata), 73'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Packing and first-beat latency
        tready = 1'b1;
        drive(1'b1, 32'hA, 1'b0);
        exp_q.push_back(beat(32'hB, 32'hA, 8'hFF, 1'b0));
        drive(1'b1, 32'hB, 1'b0);
        chk("latency_tvalid", 73'(tvalid), 73'h1);
        wait_drain("pack_drain");

        // Framing with FRAME_BEATS=4
        do_reset();
        tready = 1'b1;
        pair(1, 2, 1'b0);
        pair(3, 4, 1'b0);
        pair(5, 6, 1'b0);
        pair(7, 8, 1'b1);
        pair(9, 10, 1'b0);
        wait_drain("frame_drain");

        // Backpressure: 5 beats offered, 4 fit, the 5th is dropped
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(2 * i + 1), 1'b0);
            if (i < 4) exp_q.push_back(beat(32'(2 * i + 2), 32'(2 * i + 1), 8'hFF, i == 3));
            drive(1'b1, 32'(2 * i + 2), 1'b0);
            chk("bp_head", {tvalid, tlast, tkeep, tdata}, {1'b1, 1'b0, 8'hFF, 64'h00000002_00000001});
        end
        chk("bp_drop_count", 73'(drop_count), 73'h1);
        chk("bp_overflow", 73'(overflow), 73'h1);
        tready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_overflow_sticky", 73'(overflow), 73'h1);

        // Flush alone from HALF, then a full frame, then flush with a sample
        drive(1'b1, 32'h5, 1'b0);
        exp_q.push_back(beat(32'h0, 32'h5, 8'h0F, 1'b1));
        drive(1'b0, 32'h0, 1'b1);
        pair(11, 12, 1'b0);
        pair(13, 14, 1'b0);
        pair(15, 16, 1'b0);
        pair(17, 18, 1'b1);
        drive(1'b1, 32'h1, 1'b0);
        exp_q.push_back(beat(32'h2, 32'h1, 8'hFF, 1'b1));
        drive(1'b1, 32'h2, 1'b1);
        exp_q.push_back(beat(32'h0, 32'h3, 8'h0F, 1'b1));
        drive(1'b1, 32'h3, 1'b1);
        pair(19, 20, 1'b0);
        wait_drain("flush_drain");

        // Async reset between edges with 3 beats queued
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i + 30), 1'b0);
            drive(1'b1, 32'(i + 40), 1'b0);
        end
        drive(1'b1, 32'h99, 1'b0);
        chk("pre_reset_tvalid", 73'(tvalid), 73'h1);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_outputs", {tvalid, tlast, tkeep, drop_count, overflow}, 73'h0);
        chk("async_rst_tdata", 73'(tdata), 73'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tready = 1'b1;
        pair(7, 8, 1'b0);
        pair(9, 10, 1'b0);
        pair(11, 12, 1'b0);
        pair(13, 14, 1'b1);
        wait_drain("post_reset_drain");
        chk("post_reset_drops", {57'h0, drop_count}, 73'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axis_snoop_tx.md
AXIS_SNOOP_TX -- requirements
Module: axis_snoop_tx

Interface
REQ-001 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 64, output beat width, fixed at twice the 32-bit sample width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, beat FIFO entries, power of two and at least 2.
REQ-003 SHALL have parameter FRAME_BEATS, default 256, beats per frame, at least 1.
REQ-004 SHALL have port s00_axis_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port s00_axis_aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port sample_valid, input, 1 bit: sample strobe; there is no backpressure toward the producer.
REQ-007 SHALL have port sample_data, input, 32 bits: sample word, valid when sample_valid=1.
REQ-008 SHALL have port flush, input, 1 bit: one-cycle request to close the current frame early.
REQ-009 SHALL have port m00_axis_tready, input, 1 bit: downstream ready.
REQ-010 SHALL have port m00_axis_tvalid, output, 1 bit: beat valid.
REQ-011 SHALL have port m00_axis_tdata, output, C_M00_AXIS_TDATA_WIDTH bits: beat data, with the older sample in [31:0] and the newer sample in [63:32].
REQ-012 SHALL have port m00_axis_tkeep, output, 8 bits: 8'hFF for a full beat, 8'h0F for a padded beat.
REQ-013 SHALL have port m00_axis_tlast, output, 1 bit: last beat of a frame.
REQ-014 SHALL have port drop_count, output, 16 bits: count of dropped beats, saturating.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, set when any beat has been dropped.

Function
REQ-016 The pack FSM SHALL have two states.
- EMPTY, with sample_valid: store sample_data in the hold register and go to HALF.
- HALF, with sample_valid: form beat {sample_data, hold}, tkeep 8'hFF, push it, and go to EMPTY.
REQ-017 flush SHALL be evaluated after that cycle's sample, with the following outcomes:
- HALF without sample: push {32'h0, hold}, tkeep 8'h0F, tlast=1, go to EMPTY.
- EMPTY with sample: push {32'h0, sample_data}, tkeep 8'h0F, tlast=1, stay in EMPTY.
- HALF with sample: push the full beat with tlast=1.
- EMPTY without sample: no action.
REQ-018 The frame counter SHALL advance only on accepted pushes.
- The beat pushed at count FRAME_BEATS-1 gets tlast=1 and the counter wraps to 0.
- A flush beat resets the counter to 0.
REQ-019 A push SHALL be accepted when the FIFO holds fewer than FIFO_DEPTH entries, or when the FIFO is full and a pop occurs in the same cycle.
REQ-020 A push that is not accepted SHALL be dropped.
- drop_count increments, saturating at 16'hFFFF.
- overflow is set and stays set until reset.
- The frame counter does not advance.
- The pack FSM still returns to EMPTY.
REQ-021 m00_axis_tvalid SHALL equal "FIFO not empty"; tdata, tkeep and tlast SHALL come from the FIFO head.
REQ-022 A pop SHALL occur exactly when m00_axis_tvalid and m00_axis_tready are both 1.
REQ-023 While tvalid=1 and tready=0, tdata, tkeep and tlast SHALL stay stable, and tvalid SHALL NOT deassert.
REQ-024 Latency: a beat pushed into an empty FIFO at edge N SHALL appear with tvalid=1 in the cycle following edge N.
REQ-025 With tready held at 1, the block SHALL sustain one beat per two sample cycles with no drops.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range from 0 to FIFO_DEPTH.

Reset
REQ-027 While s00_axis_aresetn=0 the block SHALL hold the following, independent of the clock:
- Outputs: tvalid=0, tdata=0, tkeep=0, tlast=0, drop_count=0, overflow=0.
- Internal: FIFO empty, FSM in EMPTY, hold register 0, frame counter 0.
REQ-028 On reset assertion mid-frame or mid-handshake, all pending beats and any held sample SHALL be discarded.
REQ-029 The first sample accepted after reset deassertion SHALL start a new beat at frame position 0.

Verification
REQ-030 A bench SHALL cover packing: with tready=1, samples 32'hA, 32'hB -> one beat 64'h0000000B_0000000A, tkeep 8'hFF, tlast 0, tvalid high in the cycle after B's edge.
REQ-031 A bench SHALL cover framing: FRAME_BEATS=4, tready=1, 8 samples 1..8 -> beats {2,1},{4,3},{6,5},{8,7}, tlast only on {8,7}; the next beat has tlast 0.
REQ-032 A bench SHALL cover backpressure: tready=0, 10 samples, FIFO_DEPTH=4.
- Response: 4 beats buffered, 1 beat dropped, drop_count=1, overflow=1.
- Head beat {2,1} stays stable throughout.
- After tready=1, beats {2,1},{4,3},{6,5},{8,7} drain in order.
REQ-033 A bench SHALL cover flush: sample 32'h5 followed by flush alone -> beat 64'h00000000_00000005, tkeep 8'h0F, tlast 1.
- A following FRAME_BEATS-beat run ends tlast on beat FRAME_BEATS.
REQ-034 A bench SHALL cover flush with sample: in state HALF holding 32'h1, sample 32'h2 with flush in the same cycle -> beat {2,1}, tkeep 8'hFF, tlast 1.
REQ-035 A bench SHALL cover reset: async reset asserted between clock edges with 3 beats queued and tready=0.
- tvalid=0 immediately after assertion.
- After release, samples 7, 8 -> beat {8,7} at frame position 0, drop_count=0.
